// File: rtl/pic_read_roi.sv
// ROI frame reader: walks a rectangular window of a frame buffer as DRAM bursts,
// buffers the returned words in a FIFO and serves them on a pop interface.
module pic_read_roi #(
    parameter int          IMG_WIDTH  = 1600,
    parameter int          IMG_HEIGHT = 900,
    parameter int          BURST_LEN  = 64,
    parameter int          FIFO_AW    = 11,
    parameter int          NUM_FB     = 2,
    parameter logic [31:0] FB_SIZE    = 32'h0060_0000,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [1:0]         FB_SEL,
    input  logic [11:0]        ROI_X,
    input  logic [11:0]        ROI_Y,
    input  logic [11:0]        ROI_W,
    input  logic [11:0]        ROI_H,
    output logic               kick,
    input  logic               busy,
    output logic [31:0]        read_num,
    output logic [31:0]        read_addr,
    input  logic [31:0]        buf_dout,
    input  logic               buf_we,
    output logic [31:0]        dout,
    input  logic               rd_en,
    output logic [FIFO_AW:0]   rd_cnt,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               err_cfg,
    output logic               overflow
);
    localparam logic [31:0]      IMG_W32  = IMG_WIDTH;
    localparam logic [31:0]      IMG_H32  = IMG_HEIGHT;
    localparam logic [31:0]      NUM_FB32 = NUM_FB;
    localparam logic [11:0]      BURST12  = 12'(BURST_LEN);
    localparam logic [FIFO_AW:0] DEPTH_C  = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_KICK, S_BUSY, S_SPACE, S_DONE} state_t;
    state_t state, state_n;

    logic        start_q1, start_q2, start_edge;
    logic [12:0] x_end, y_end;
    logic        cfg_bad;
    logic [1:0]  cfg_fb;
    logic [11:0] cfg_x, cfg_y, cfg_w, cfg_h;
    logic [11:0] x_cnt, y_cnt, remain, num_calc, x_next;
    logic [31:0] pix_idx, addr_calc, free32;
    logic        fits_calc, fits_num, abort_pend, flush;

    logic [31:0]        mem [DEPTH_C];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic               full, wr_do, rd_do;

    assign start_edge = start_q1 & ~start_q2;
    assign x_end      = {1'b0, ROI_X} + {1'b0, ROI_W};
    assign y_end      = {1'b0, ROI_Y} + {1'b0, ROI_H};
    assign cfg_bad    = (ROI_W == '0) || (ROI_H == '0) || ({19'b0, x_end} > IMG_W32) ||
                        ({19'b0, y_end} > IMG_H32) || ({30'b0, FB_SEL} >= NUM_FB32);

    assign remain    = cfg_w - x_cnt;
    assign num_calc  = (remain > BURST12) ? BURST12 : remain;
    assign x_next    = x_cnt + num_calc;
    assign pix_idx   = ({20'b0, cfg_y} + {20'b0, y_cnt}) * IMG_W32 + {20'b0, cfg_x} + {20'b0, x_cnt};
    assign addr_calc = BASE_ADDR + FB_SIZE * {30'b0, cfg_fb} + {pix_idx[29:0], 2'b00};
    assign free32    = 32'(DEPTH_C - rd_cnt);
    assign fits_calc = free32 >= {20'b0, num_calc};
    assign fits_num  = free32 >= read_num;

    assign full  = (rd_cnt == DEPTH_C);
    assign wr_do = buf_we & ~full;
    assign rd_do = rd_en & (rd_cnt != '0);

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_n;
    end

    // An abort that lands while a burst is in flight waits for busy to drop.
    always_comb begin
        state_n = state;
        flush   = 1'b0;
        unique case (state)
            S_IDLE:  if (start_edge && !cfg_bad) state_n = S_CALC;
            S_CALC:  if (ABORT) begin
                         state_n = S_IDLE;
                         flush   = 1'b1;
                     end else state_n = fits_calc ? S_KICK : S_SPACE;
            S_SPACE: if (ABORT) begin
                         state_n = S_IDLE;
                         flush   = 1'b1;
                     end else if (fits_num) state_n = S_KICK;
            S_KICK:  if (busy) state_n = S_BUSY;
                     else if (ABORT) begin
                         state_n = S_IDLE;
                         flush   = 1'b1;
                     end
            S_BUSY:  if (!busy) begin
                         if (abort_pend || ABORT) begin
                             state_n = S_IDLE;
                             flush   = 1'b1;
                         end else if (y_cnt == cfg_h) state_n = S_DONE;
                         else state_n = S_CALC;
                     end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        kick       = (state == S_KICK);
        frame_done = (state == S_DONE);
        frame_busy = (state == S_CALC) || (state == S_KICK) ||
                     (state == S_BUSY) || (state == S_SPACE);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            start_q1   <= 1'b0;
            start_q2   <= 1'b0;
            err_cfg    <= 1'b0;
            overflow   <= 1'b0;
            abort_pend <= 1'b0;
            cfg_fb     <= '0;
            cfg_x      <= '0;
            cfg_y      <= '0;
            cfg_w      <= '0;
            cfg_h      <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            read_num   <= '0;
            read_addr  <= '0;
        end else begin
            start_q1 <= START;
            start_q2 <= start_q1;
            err_cfg  <= 1'b0;
            if (state == S_IDLE && start_edge) begin
                if (cfg_bad) err_cfg <= 1'b1;
                else begin
                    cfg_fb   <= FB_SEL;
                    cfg_x    <= ROI_X;
                    cfg_y    <= ROI_Y;
                    cfg_w    <= ROI_W;
                    cfg_h    <= ROI_H;
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    overflow <= 1'b0;
                end
            end
            if (buf_we && full) overflow <= 1'b1;
            if (state == S_CALC && !ABORT) begin
                read_addr <= addr_calc;
                read_num  <= {20'b0, num_calc};
                if (x_next == cfg_w) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 12'd1;
                end else x_cnt <= x_next;
            end
            if (state == S_IDLE) abort_pend <= 1'b0;
            else if ((state == S_BUSY || (state == S_KICK && busy)) && ABORT) abort_pend <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_do) mem[wr_ptr] <= buf_dout;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
            dout   <= '0;
        end else begin
            if (rd_do) dout <= mem[rd_ptr];
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                rd_cnt <= '0;
            end else begin
                if (wr_do) wr_ptr <= wr_ptr + 1'b1;
                if (rd_do) rd_ptr <= rd_ptr + 1'b1;
                case ({wr_do, rd_do})
                    2'b10:   rd_cnt <= rd_cnt + 1'b1;
                    2'b01:   rd_cnt <= rd_cnt - 1'b1;
                    default: rd_cnt <= rd_cnt;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pic_read_roi.sv
// Randomised bench for pic_read_roi: DRAM responder, random consumer, queue-based
// FIFO model and a burst list derived directly from the ROI geometry.
module tb_pic_read_roi;
    localparam int          W     = 128;
    localparam int          H     = 4;
    localparam int          BURST = 64;
    localparam int          AW    = 8;
    localparam int          DEPTH = 256;
    localparam logic [31:0] FBSZ  = 32'h0001_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] num;
    } burst_t;

    logic        CLK = 1'b0;
    logic        RST_N, START, ABORT, kick, busy, buf_we, rd_en;
    logic [1:0]  FB_SEL;
    logic [11:0] ROI_X, ROI_Y, ROI_W, ROI_H;
    logic [31:0] read_num, read_addr, buf_dout, dout;
    logic [AW:0] rd_cnt;
    logic        frame_busy, frame_done, err_cfg, overflow;

    int          vecs = 0, errs = 0, ndone = 0, nwr = 0;
    int          inj_req = 0, inj_done = 0;
    bit          cons_en = 1'b0;
    burst_t      bq[$];
    logic [31:0] fq[$];

    pic_read_roi #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BURST_LEN(BURST), .FIFO_AW(AW),
                   .NUM_FB(2), .FB_SIZE(FBSZ), .BASE_ADDR(32'h0)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT), .FB_SEL(FB_SEL),
        .ROI_X(ROI_X), .ROI_Y(ROI_Y), .ROI_W(ROI_W), .ROI_H(ROI_H),
        .kick(kick), .busy(busy), .read_num(read_num), .read_addr(read_addr),
        .buf_dout(buf_dout), .buf_we(buf_we), .dout(dout), .rd_en(rd_en), .rd_cnt(rd_cnt),
        .frame_busy(frame_busy), .frame_done(frame_done), .err_cfg(err_cfg), .overflow(overflow));

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expected bursts: row by row, BURST-sized chunks with a short tail per row.
    task automatic build(input int fb, input int x, input int y, input int w, input int h);
        bq.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c += BURST) begin
                burst_t b;
                b.addr = FBSZ * 32'(fb) + 32'(((y + r) * W + x + c) * 4);
                b.num  = 32'((w - c < BURST) ? w - c : BURST);
                bq.push_back(b);
            end
        end
    endtask

    task automatic set_roi(input int fb, input int x, input int y, input int w, input int h);
        FB_SEL = 2'(fb); ROI_X = 12'(x); ROI_Y = 12'(y); ROI_W = 12'(w); ROI_H = 12'(h);
    endtask

    task automatic start_pulse();
        @(negedge CLK); START = 1'b1;
        repeat (2) @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0 = ndone;
        int t  = 0;
        while (ndone == n0 && t < budget) begin @(negedge CLK); t++; end
        repeat (3) @(negedge CLK);
        chk("frame_done_count", 32'(ndone - n0), 32'd1);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        cons_en = 1'b1;
        while (fq.size() != 0 && t < budget) begin @(negedge CLK); t++; end
        chk("drain_empty", 32'(fq.size()), 32'd0);
    endtask

    task automatic frame(input int fb, input int x, input int y, input int w, input int h);
        build(fb, x, y, w, h);
        set_roi(fb, x, y, w, h);
        cons_en = 1'b1;
        start_pulse();
        wait_done(6000);
        chk("bursts_left", 32'(bq.size()), 32'd0);
        drain(3000);
    endtask

    task automatic cfg_reject(input int fb, input int x, input int y, input int w, input int h);
        int ne = 0, nk = 0, nb = 0;
        set_roi(fb, x, y, w, h);
        @(negedge CLK); START = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (i == 1) START = 1'b0;
            ne += int'(err_cfg); nk += int'(kick); nb += int'(frame_busy);
        end
        chk("err_cfg_pulses", 32'(ne), 32'd1);
        chk("reject_no_kick", 32'(nk), 32'd0);
        chk("reject_not_busy", 32'(nb), 32'd0);
    endtask

    // DRAM responder: random kick->busy latency, random gaps between returned words.
    initial begin : dram
        logic [31:0] a, n;
        busy = 1'b0; buf_we = 1'b0; buf_dout = '0;
        forever begin
            @(negedge CLK);
            if (inj_req != inj_done) begin
                buf_we = 1'b1; buf_dout = $urandom; inj_done++;
            end else begin
                buf_we = 1'b0;
                if (kick) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    if (kick) begin
                        a = read_addr; n = (read_num > 32'd300) ? 32'd300 : read_num;
                        busy = 1'b1;
                        @(negedge CLK);
                        for (int i = 0; i < int'(n); i++) begin
                            while ($urandom_range(0, 3) == 0) begin buf_we = 1'b0; @(negedge CLK); end
                            buf_we = 1'b1; buf_dout = a + 32'(4 * i);
                            @(negedge CLK);
                        end
                        buf_we = 1'b0; busy = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : consumer
        rd_en = 1'b0;
        forever begin
            @(negedge CLK);
            rd_en = cons_en && ($urandom_range(0, 1) == 1);
        end
    end

    initial begin : compare
        logic        we_s, re_s, rst_s, popped, fb_prev, kick_prev;
        logic [31:0] d_s, exp_d;
        int          n0;
        burst_t      b;
        fb_prev = 1'b0; kick_prev = 1'b0; exp_d = '0;
        forever begin
            @(posedge CLK);
            we_s = buf_we; re_s = rd_en; rst_s = RST_N; d_s = buf_dout;
            popped = 1'b0; n0 = fq.size();
            if (rst_s === 1'b1) begin
                if (re_s && n0 > 0) begin exp_d = fq.pop_front(); popped = 1'b1; end
                if (we_s && n0 < DEPTH) begin fq.push_back(d_s); nwr++; end
            end
            #1;
            if (rst_s !== 1'b1 || (fb_prev && !frame_busy && !frame_done)) fq.delete();
            if (popped) chk("dout", dout, exp_d);
            chk("rd_cnt", 32'(rd_cnt), 32'(fq.size()));
            if (kick && !kick_prev) begin
                vecs++;
                if (bq.size() == 0) begin
                    errs++;
                    $display("FAIL extra_kick: got kick addr %0h num %0d, expected none", read_addr, read_num);
                end else begin
                    b = bq.pop_front();
                    vecs--;
                    chk("burst_addr", read_addr, b.addr);
                    chk("burst_num", read_num, b.num);
                end
            end
            if (frame_done) ndone++;
            fb_prev = frame_busy; kick_prev = kick;
        end
    end

    initial begin : main
        int n0, t, nk, d0;
        RST_N = 1'b0; START = 1'b0; ABORT = 1'b0;
        set_roi(0, 0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        chk("rst_kick", 32'(kick), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_frame_busy", 32'(frame_busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err_cfg", 32'(err_cfg), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_read_num", read_num, 32'd0);
        chk("rst_read_addr", read_addr, 32'd0);
        chk("rst_dout", dout, 32'd0);
        RST_N = 1'b1;

        // Partial-tail ROI; pin the model against hand-computed bursts first.
        build(1, 16, 2, 100, 2);
        chk("model_n", 32'(bq.size()), 32'd4);
        chk("model_a0", bq[0].addr, 32'h10440); chk("model_n0", bq[0].num, 32'd64);
        chk("model_a1", bq[1].addr, 32'h10540); chk("model_n1", bq[1].num, 32'd36);
        chk("model_a2", bq[2].addr, 32'h10640); chk("model_n3", bq[3].num, 32'd36);
        n0 = nwr;
        frame(1, 16, 2, 100, 2);
        chk("roi_words", 32'(nwr - n0), 32'd200);

        // Full frame with no consumer: FIFO fills after 4 bursts and the reader parks.
        build(0, 0, 0, W, H);
        chk("model_full_a7", bq[7].addr, 32'h700);
        set_roi(0, 0, 0, W, H);
        cons_en = 1'b0;
        start_pulse();
        t = 0;
        while (rd_cnt != 9'(DEPTH) && t < 3000) begin @(negedge CLK); t++; end
        repeat (10) @(negedge CLK);
        chk("space_full", 32'(rd_cnt), 32'(DEPTH));
        chk("space_kick_low", 32'(kick), 32'd0);
        chk("space_frame_busy", 32'(frame_busy), 32'd1);
        chk("space_bursts_issued", 32'(8 - bq.size()), 32'd4);
        cons_en = 1'b1;
        t = 0;
        while (rd_cnt > 9'd192 && t < 1000) begin @(negedge CLK); t++; end
        cons_en = 1'b0;
        t = 0;
        while (!kick && t < 20) begin @(negedge CLK); t++; end
        chk("space_release_kick", 32'(kick), 32'd1);
        cons_en = 1'b1;
        wait_done(6000);
        chk("full_bursts_left", 32'(bq.size()), 32'd0);
        drain(3000);

        cfg_reject(0, 100, 0, 64, 1);
        cfg_reject(2, 0, 0, 16, 1);
        cfg_reject(0, 0, 0, 16, 0);

        // Overflow: push DEPTH+1 words with nothing consuming, then a good START clears it.
        cons_en = 1'b0;
        @(negedge CLK);
        inj_req = inj_req + DEPTH + 1;
        t = 0;
        while (inj_done != inj_req && t < 600) begin @(negedge CLK); t++; end
        repeat (2) @(negedge CLK);
        chk("ovf_rd_cnt", 32'(rd_cnt), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        build(1, 0, 0, 32, 1);
        set_roi(1, 0, 0, 32, 1);
        start_pulse();
        t = 0;
        while (!frame_busy && t < 10) begin @(negedge CLK); t++; end
        chk("ovf_cleared", 32'(overflow), 32'd0);
        cons_en = 1'b1;
        wait_done(3000);
        drain(3000);

        // Abort during a burst: burst completes, FIFO flushed, no frame_done.
        build(0, 0, 0, W, H);
        set_roi(0, 0, 0, W, H);
        cons_en = 1'b0;
        d0 = ndone;
        start_pulse();
        t = 0;
        while (!busy && t < 100) begin @(negedge CLK); t++; end
        ABORT = 1'b1;
        @(negedge CLK); ABORT = 1'b0;
        t = 0;
        while (frame_busy && t < 500) begin @(negedge CLK); t++; end
        chk("abort_idle", 32'(frame_busy), 32'd0);
        chk("abort_flush", 32'(rd_cnt), 32'd0);
        chk("abort_bursts", 32'(8 - bq.size()), 32'd1);
        nk = 0;
        repeat (20) begin @(negedge CLK); nk += int'(kick); end
        chk("abort_no_kick", 32'(nk), 32'd0);
        chk("abort_no_done", 32'(ndone - d0), 32'd0);

        // Random legal ROIs.
        for (int i = 0; i < 4; i++) begin
            int w = $urandom_range(1, W);
            int h = $urandom_range(1, H);
            frame($urandom_range(0, 1), $urandom_range(0, W - w), $urandom_range(0, H - h), w, h);
        end

        // Reset mid-frame.
        build(1, 0, 0, W, H);
        set_roi(1, 0, 0, W, H);
        cons_en = 1'b1;
        start_pulse();
        t = 0;
        while (!(busy && bq.size() <= 6) && t < 3000) begin @(negedge CLK); t++; end
        RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_kick", 32'(kick), 32'd0);
        chk("mid_rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("mid_rst_frame_busy", 32'(frame_busy), 32'd0);
        RST_N = 1'b1;
        t = 0;
        while (busy && t < 500) begin @(negedge CLK); t++; end
        drain(3000);
        frame(0, 8, 1, 70, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
